// File: rtl/axis_insert_header_arbiter.sv
// axis_insert_header_arbiter
//   Round-robin front end that lets NUM_SRC requesters share a single
//   header-inserter. One requester is granted at a time. Its header is
//   forwarded first, then its whole packet. The grant stays locked until the
//   last data beat of that packet has been accepted downstream.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_*_insert          per-source header channel (valid/data/keep/cnt in, ready out)
//   s_*_in              per-source data channel (valid/data/keep/last in, ready out)
//   m_*_insert          header channel towards the inserter
//   m_*_in              data channel towards the inserter
//   grant_id            index of the current grant, or the most recent one
//   busy                high whenever a grant is active (state != IDLE)
//   pkt_done            one-cycle pulse after the last data beat is accepted
//
// state | meaning
// IDLE  | no grant; arbitrate among the header valids
// HDR   | granted source's header routed to the inserter
// PKT   | granted source's data beats routed until last is accepted
module axis_insert_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_WD       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,

  input  logic [NUM_SRC-1:0]              s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_byte_insert_cnt,
  output logic [NUM_SRC-1:0]              s_ready_insert,

  input  logic [NUM_SRC-1:0]              s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in,
  input  logic [NUM_SRC-1:0]              s_last_in,
  output logic [NUM_SRC-1:0]              s_ready_in,

  output logic                            m_valid_insert,
  output logic [DATA_WD-1:0]              m_data_insert,
  output logic [DATA_BYTE_WD-1:0]         m_keep_insert,
  output logic [BYTE_CNT_WD-1:0]          m_byte_insert_cnt,
  input  logic                            m_ready_insert,

  output logic                            m_valid_in,
  output logic [DATA_WD-1:0]              m_data_in,
  output logic [DATA_BYTE_WD-1:0]         m_keep_in,
  output logic                            m_last_in,
  input  logic                            m_ready_in,

  output logic [SRC_WD-1:0]               grant_id,
  output logic                            busy,
  output logic                            pkt_done
);

  typedef enum logic [1:0] {IDLE, HDR, PKT} state_t;

  state_t            state;
  logic [SRC_WD-1:0] rr_ptr;
  logic [SRC_WD-1:0] winner;
  logic [SRC_WD-1:0] next_rr;
  logic [SRC_WD:0]   rot_idx;
  logic              found;
  logic              hdr_phase;
  logic              pkt_phase;
  logic              hdr_done;
  logic              last_done;

  // First requesting source at or after rr_ptr, wrapping modulo NUM_SRC.
  // The extra index bit keeps the wrap correct for non-power-of-two NUM_SRC.
  always_comb begin
    winner  = rr_ptr;
    found   = 1'b0;
    rot_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rot_idx = {1'b0, rr_ptr} + (SRC_WD+1)'(i);
      if (rot_idx >= (SRC_WD+1)'(NUM_SRC))
        rot_idx = rot_idx - (SRC_WD+1)'(NUM_SRC);
      if (!found && s_valid_insert[rot_idx[SRC_WD-1:0]]) begin
        winner = rot_idx[SRC_WD-1:0];
        found  = 1'b1;
      end
    end
  end

  assign next_rr = (grant_id == SRC_WD'(NUM_SRC-1)) ? '0 : grant_id + SRC_WD'(1);

  assign hdr_phase = (state == HDR);
  assign pkt_phase = (state == PKT);
  assign busy      = (state != IDLE);

  assign m_valid_insert    = hdr_phase & s_valid_insert[grant_id];
  assign m_data_insert     = s_data_insert[grant_id*DATA_WD +: DATA_WD];
  assign m_keep_insert     = s_keep_insert[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign m_byte_insert_cnt = s_byte_insert_cnt[grant_id*BYTE_CNT_WD +: BYTE_CNT_WD];

  assign m_valid_in = pkt_phase & s_valid_in[grant_id];
  assign m_data_in  = s_data_in[grant_id*DATA_WD +: DATA_WD];
  assign m_keep_in  = s_keep_in[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign m_last_in  = s_last_in[grant_id];

  // Readies come only from the downstream readies, steered by state and grant,
  // so no source valid ever loops back into a source ready.
  always_comb begin
    s_ready_insert = '0;
    s_ready_in     = '0;
    if (hdr_phase) s_ready_insert[grant_id] = m_ready_insert;
    if (pkt_phase) s_ready_in[grant_id]     = m_ready_in;
  end

  assign hdr_done  = m_valid_insert & m_ready_insert;
  assign last_done = m_valid_in & m_ready_in & m_last_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (|s_valid_insert) begin
            grant_id <= winner;
            state    <= HDR;
          end
        end
        HDR: begin
          if (hdr_done) state <= PKT;
        end
        PKT: begin
          if (last_done) begin
            pkt_done <= 1'b1;
            rr_ptr   <= next_rr;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
